// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully connected output layer.
package fc_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} fc_state_e;

  // Full signed product plus headroom for INNODE additions.
  function automatic int unsigned acc_width(int unsigned width, int unsigned innode);
    return 2 * width + $clog2(innode);
  endfunction

  function automatic int sat_max(int unsigned width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(int unsigned width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantiser: arithmetic shift of the accumulator, bias add, saturate to WIDTH.
module fc_requant
  import fc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 4,
  parameter int unsigned ACC_W = 19
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] res
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] MaxVal = SUM_W'(sat_max(WIDTH));
  localparam logic signed [SUM_W-1:0] MinVal = SUM_W'(sat_min(WIDTH));

  logic signed [ACC_W-1:0] shifted;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    shifted = acc >>> FRAC;
    sum     = SUM_W'(shifted) + SUM_W'(bias);
    if (sum > MaxVal) begin
      res = MaxVal[WIDTH-1:0];
    end else if (sum < MinVal) begin
      res = MinVal[WIDTH-1:0];
    end else begin
      res = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully connected layer: one MAC per cycle against an external 1-cycle weight ROM,
// requantised per output node and published as a packed score vector.
module fc_layer
  import fc_pkg::*;
#(
  parameter int unsigned INNODE  = 16,
  parameter int unsigned OUTNODE = 10,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned FRAC    = 4,
  localparam int unsigned N      = INNODE * OUTNODE,
  localparam int unsigned AW     = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH*INNODE-1:0]    in,
  input  logic [WIDTH*OUTNODE-1:0]   bias,
  output logic                       w_rd,
  output logic [AW-1:0]              w_addr,
  input  logic [WIDTH-1:0]           w_data,
  output logic [WIDTH*OUTNODE-1:0]   out,
  output logic                       valid,
  output logic                       busy
);

  localparam int unsigned IW    = (INNODE > 1) ? $clog2(INNODE) : 1;
  localparam int unsigned JW    = (OUTNODE > 1) ? $clog2(OUTNODE) : 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned ACC_W = acc_width(WIDTH, INNODE);

  fc_state_e               state_q;
  logic [AW-1:0]           cnt_q;
  logic [IW-1:0]           i_q, tag_i_q;
  logic [JW-1:0]           j_q, tag_j_q;
  logic                    tag_vld_q, tag_last_q;
  logic signed [WIDTH-1:0] x_q   [INNODE];
  logic signed [WIDTH-1:0] res_q [OUTNODE];
  logic signed [ACC_W-1:0] acc_q;

  logic signed [WIDTH-1:0] in_a   [INNODE];
  logic signed [WIDTH-1:0] bias_a [OUTNODE];
  logic signed [WIDTH-1:0] res_d  [OUTNODE];
  logic [WIDTH*OUTNODE-1:0] out_d;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [WIDTH-1:0] bias_j, req;

  assign w_rd   = (state_q == StRun);
  assign w_addr = cnt_q;
  assign valid  = (state_q == StDone);
  assign busy   = (state_q != StIdle);

  // Element 0 sits in the MSB slice of both packed inputs.
  always_comb begin
    for (int k = 0; k < INNODE; k++) in_a[k] = in[(INNODE-1-k)*WIDTH +: WIDTH];
  end

  always_comb begin
    for (int k = 0; k < OUTNODE; k++) bias_a[k] = bias[(OUTNODE-1-k)*WIDTH +: WIDTH];
  end

  always_comb begin
    prod    = PW'(x_q[tag_i_q]) * PW'($signed(w_data));
    acc_sum = acc_q + ACC_W'(prod);
    bias_j  = bias_a[tag_j_q];
  end

  fc_requant #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_requant (
    .acc  (acc_sum),
    .bias (bias_j),
    .res  (req)
  );

  // res_d includes the row finishing this cycle so DRAIN can publish the last node at once.
  always_comb begin
    res_d = res_q;
    if (tag_vld_q && tag_last_q) res_d[tag_j_q] = req;
    out_d = '0;
    for (int k = 0; k < OUTNODE; k++) out_d[(OUTNODE-1-k)*WIDTH +: WIDTH] = res_d[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      tag_vld_q  <= 1'b0;
      tag_i_q    <= '0;
      tag_j_q    <= '0;
      tag_last_q <= 1'b0;
      acc_q      <= '0;
      out        <= '0;
      for (int k = 0; k < INNODE; k++) x_q[k] <= '0;
      for (int k = 0; k < OUTNODE; k++) res_q[k] <= '0;
    end else begin
      tag_vld_q  <= (state_q == StRun);
      tag_i_q    <= i_q;
      tag_j_q    <= j_q;
      tag_last_q <= (i_q == IW'(INNODE - 1));
      if (tag_vld_q) acc_q <= tag_last_q ? '0 : acc_sum;
      res_q <= res_d;

      unique case (state_q)
        // DONE doubles as an accept slot so back-to-back inferences take N+2 cycles.
        StIdle, StDone: begin
          if (start) begin
            for (int k = 0; k < INNODE; k++) x_q[k] <= in_a[k];
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (cnt_q == AW'(N - 1)) begin
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (i_q == IW'(INNODE - 1)) begin
              i_q <= '0;
              j_q <= j_q + 1'b1;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end
        end
        StDrain: begin
          out     <= out_d;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer (4 inputs, 3 outputs): cycle-level reference model with a per-cycle
// compare, plus directed scenarios with literal expected scores.
module tb_fc_layer;

  localparam int INNODE  = 4;
  localparam int OUTNODE = 3;
  localparam int WIDTH   = 8;
  localparam int FRAC    = 4;
  localparam int N       = INNODE * OUTNODE;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   in_v = '0;
  logic [23:0]   bias_v = '0;
  logic          w_rd;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data = '0;
  logic [23:0]   out;
  logic          valid;
  logic          busy;

  logic signed [7:0] rom [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_layer #(
    .INNODE  (INNODE),
    .OUTNODE (OUTNODE),
    .WIDTH   (WIDTH),
    .FRAC    (FRAC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in     (in_v),
    .bias   (bias_v),
    .w_rd   (w_rd),
    .w_addr (w_addr),
    .w_data (w_data),
    .out    (out),
    .valid  (valid),
    .busy   (busy)
  );

  // External weight memory: one-cycle read latency.
  always @(posedge clk) if (w_rd) w_data <= rom[w_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scores straight from the arithmetic: dot product, floor divide by 2^FRAC, bias, clamp.
  function automatic logic [23:0] model_result(input logic [31:0] xin, input logic [23:0] b);
    logic [23:0] r;
    r = '0;
    for (int j = 0; j < OUTNODE; j++) begin
      int s;
      int v;
      s = 0;
      for (int i = 0; i < INNODE; i++)
        s += int'($signed(xin[(INNODE-1-i)*8 +: 8])) * int'(rom[j*INNODE+i]);
      v = (s >>> FRAC) + int'($signed(b[(OUTNODE-1-j)*8 +: 8]));
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      r[(OUTNODE-1-j)*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  // Reference timing: t counts edges since acceptance, -1 when idle.
  int          t = -1;
  bit          armed = 1'b0;
  logic [23:0] m_out = '0;
  logic [23:0] m_pending = '0;

  always @(posedge clk) begin
    if (reset) begin
      t = -1;
      m_out = '0;
      armed = 1'b1;
    end else if ((t == -1 || t == N + 1) && start) begin
      t = 0;
      m_pending = model_result(in_v, bias_v);
    end else if (t >= 0) begin
      t++;
      if (t == N + 2) t = -1;
    end
    if (t == N + 1) m_out = m_pending;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", busy, t >= 0);
      check("valid", valid, t == N + 1);
      check("w_rd", w_rd, t >= 0 && t < N);
      if (t >= 0 && t < N) check("w_addr", w_addr, t);
      check("out", out, m_out);
    end
  end

  task automatic set_x(input int a, input int b, input int c, input int d);
    in_v = {8'(a), 8'(b), 8'(c), 8'(d)};
  endtask

  task automatic set_bias(input int b0, input int b1, input int b2);
    bias_v = {8'(b0), 8'(b1), 8'(b2)};
  endtask

  task automatic set_rows(input int w0, input int w1, input int w2);
    for (int i = 0; i < INNODE; i++) begin
      rom[i]            = 8'(w0);
      rom[INNODE+i]     = 8'(w1);
      rom[2*INNODE+i]   = 8'(w2);
    end
  endtask

  task automatic run(input string name, input logic [23:0] want, input int mid,
                     input bit chk_addr);
    int n;
    int addrs[$];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!valid && n < 40) begin
      if (w_rd) addrs.push_back(int'(w_addr));
      @(negedge clk);
      n++;
      start = (n == mid);
    end
    start = 1'b0;
    check($sformatf("%s latency", name), n, 13);
    check(name, out, want);
    if (chk_addr) begin
      check("addr count", addrs.size(), N);
      foreach (addrs[k]) check($sformatf("addr %0d", k), addrs[k], k);
    end
    @(negedge clk);
  endtask

  function automatic int argmax3(input logic [23:0] v);
    logic signed [7:0] a [3];
    int best;
    for (int j = 0; j < 3; j++) a[j] = v[(2-j)*8 +: 8];
    best = 0;
    for (int j = 1; j < 3; j++) if (a[j] > a[best]) best = j;
    return best;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int n;
    int vcount;
    int vq[$];
    set_rows(0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset out", out, 0);
    check("reset busy", busy, 0);
    check("reset valid", valid, 0);
    check("reset w_rd", w_rd, 0);
    check("reset w_addr", w_addr, 0);

    set_x(16, 16, 16, 16); set_rows(16, 16, 16); set_bias(0, 0, 0);
    run("basic", 24'h404040, -1, 1'b1);

    set_x(127, 127, 127, 127); set_rows(127, -128, 0);
    run("saturate", 24'h7F8000, -1, 1'b0);

    set_x(1, 0, 0, 0); set_rows(-1, -1, -1);
    run("floor bias0", 24'hFFFFFF, -1, 1'b0);
    set_bias(5, 5, 5);
    run("floor bias5", 24'h040404, -1, 1'b0);

    set_x(16, 16, 16, 16); set_rows(16, 16, 16);
    run("basic bias5 midstart", 24'h454545, 4, 1'b0);

    // Back-to-back with start held high.
    set_bias(0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (vq.size() < 3 && n < 80) begin
      @(negedge clk);
      n++;
      if (valid) begin
        vq.push_back(n);
        if (vq.size() == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b pulses", vq.size(), 3);
    if (vq.size() == 3) begin
      check("b2b first", vq[0], 14);
      check("b2b gap1", vq[1] - vq[0], 14);
      check("b2b gap2", vq[2] - vq[1], 14);
    end
    check("b2b out", out, 24'h404040);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b idle", busy, 0);

    // Reset sampled at E6 of a run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort out", out, 0);
    check("abort w_rd", w_rd, 0);
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("abort valid count", vcount, 0);
    run("after abort", 24'h404040, -1, 1'b0);

    // Argmax hookup on zero inputs with biases (-3, 20, 7).
    set_x(0, 0, 0, 0); set_bias(-3, 20, 7);
    run("argmax scores", 24'hFD1407, -1, 1'b0);
    check("argmax index", argmax3(out), 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
